// File: rtl/mul_seq_if.sv
// Request/response bundle for the iterative multiplier.
// The master drives operands and start; the slave returns status and the HI/LO product.
interface mul_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, is_signed, op_a, op_b,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, is_signed, op_a, op_b,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mul_seq_unit.sv
// Shift-and-add 32x32 multiplier for MULT/MULTU: one adder step per cycle over 32 cycles,
// followed by a sign-fix cycle that writes the HI/LO pair.
module mul_seq_unit #(
    parameter int unsigned WIDTH = 32
) (
    input logic       clk,
    input logic       rst_n,
    mul_seq_if.slave  bus
);
    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0]   OneW = {{(WIDTH - 1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] OneP = {{(2 * WIDTH - 1){1'b0}}, 1'b1};
    localparam logic [CntW-1:0]    CntOne = {{(CntW - 1){1'b0}}, 1'b1};
    localparam logic [CntW-1:0]    CntLast = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

    state_e               state_q, state_d;
    logic [2*WIDTH-1:0]   p_q, p_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic                 neg_q, neg_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;

    logic [WIDTH-1:0]     abs_a, abs_b, addend;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   p_fix;

    // Magnitudes of the most negative value wrap to themselves, read as unsigned.
    always_comb begin
        abs_a  = (bus.is_signed && bus.op_a[WIDTH-1]) ? (~bus.op_a + OneW) : bus.op_a;
        abs_b  = (bus.is_signed && bus.op_b[WIDTH-1]) ? (~bus.op_b + OneW) : bus.op_b;
        addend = p_q[0] ? mcand_q : '0;
        sum    = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        p_fix  = neg_q ? (~p_q + OneP) : p_q;
    end

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        mcand_d = mcand_q;
        neg_d   = neg_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (bus.start) begin
                    mcand_d = abs_a;
                    p_d     = {{WIDTH{1'b0}}, abs_b};
                    neg_d   = bus.is_signed & (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
                    cnt_d   = '0;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                // Carry-out of the adder becomes the new MSB as the product shifts right.
                p_d   = {sum, p_q[WIDTH-1:1]};
                cnt_d = cnt_q + CntOne;
                if (cnt_q == CntLast) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                p_d     = p_fix;
                hi_d    = p_fix[2*WIDTH-1:WIDTH];
                lo_d    = p_fix[WIDTH-1:0];
                state_d = StDone;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            p_q     <= '0;
            mcand_q <= '0;
            neg_q   <= 1'b0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            mcand_q <= mcand_d;
            neg_q   <= neg_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign bus.busy = (state_q == StCalc) || (state_q == StFix);
    assign bus.done = (state_q == StDone);
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mul_seq_unit.sv
// Bench for mul_seq_unit: a cycle-timed product model checked every cycle, plus directed
// corner multiplies with literal expectations and a randomized request stream.
module tb_mul_seq_unit;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mul_seq_if #(.WIDTH(32)) bus ();

    mul_seq_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] model_prod(input logic sgn, input logic [31:0] a,
                                               input logic [31:0] b);
        logic signed [63:0] sa, sb;
        if (sgn) begin
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
            return 64'(sa * sb);
        end
        return {32'h0, a} * {32'h0, b};
    endfunction

    // Model: a request accepted at edge k shows busy after k..k+32, result at k+33,
    // done in the cycle after k+33, and a new request may be taken at k+34.
    int          cyc = 0;
    int          acc = 0;
    bit          active = 1'b0;
    logic [63:0] pend = '0;
    logic [63:0] exp_res = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active  = 1'b0;
            exp_res = '0;
        end else begin
            cyc++;
            if (active && cyc == acc + 33) exp_res = pend;
            if (active && cyc == acc + 34) active = 1'b0;
            if (!active && bus.start) begin
                active = 1'b1;
                acc    = cyc;
                pend   = model_prod(bus.is_signed, bus.op_a, bus.op_b);
            end
        end
    end

    always @(negedge clk) begin
        int d;
        d = cyc - acc;
        chk("cyc_busy", {63'h0, bus.busy}, {63'h0, (active && d <= 32) ? 1'b1 : 1'b0});
        chk("cyc_done", {63'h0, bus.done}, {63'h0, (active && d == 33) ? 1'b1 : 1'b0});
        chk("cyc_hilo", {bus.hi, bus.lo}, exp_res);
    end

    task automatic wait_done(input string name);
        for (int i = 0; i < 40 && !bus.done; i++) @(negedge clk);
        chk({name, "_done_seen"}, {63'h0, bus.done}, 64'h1);
    endtask

    task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input string name, input bit inject);
        int t0;
        bus.start = 1'b1; bus.is_signed = sgn; bus.op_a = a; bus.op_b = b;
        @(negedge clk);
        bus.start = 1'b0;
        t0 = cyc;
        if (inject) begin
            repeat (5) @(negedge clk);
            bus.start = 1'b1; bus.is_signed = 1'b0; bus.op_a = 32'd9; bus.op_b = 32'd9;
            @(negedge clk);
            bus.start = 1'b0;
        end
        wait_done(name);
        chk({name, "_latency"}, 64'(cyc - t0), 64'd33);
        chk({name, "_result"}, {bus.hi, bus.lo}, exp);
        @(negedge clk);
        chk({name, "_done_width"}, {63'h0, bus.done}, 64'h0);
    endtask

    initial begin
        int c1;
        int ndone;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.is_signed = 1'b0; bus.op_a = '0; bus.op_b = '0;
        repeat (3) @(negedge clk);
        chk("reset_hi", {32'h0, bus.hi}, 64'h0);
        chk("reset_lo", {32'h0, bus.lo}, 64'h0);
        chk("reset_busy", {63'h0, bus.busy}, 64'h0);
        chk("reset_done", {63'h0, bus.done}, 64'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Pin the model itself against hand-computed products.
        chk("model_u_ff", model_prod(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF), 64'hFFFFFFFE_00000001);
        chk("model_s_m3x7", model_prod(1'b1, 32'hFFFFFFFD, 32'd7), 64'hFFFFFFFF_FFFFFFEB);
        chk("model_s_min2", model_prod(1'b1, 32'h80000000, 32'h80000000), 64'h40000000_00000000);

        run_op(1'b0, 32'd3, 32'd5, 64'h0000000F, "mulu_3x5", 1'b0);
        run_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, "mulu_ffxff", 1'b0);
        run_op(1'b1, 32'hFFFFFFFD, 32'd7, 64'hFFFFFFFF_FFFFFFEB, "mult_m3x7", 1'b0);
        run_op(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h1, "mult_m1xm1", 1'b0);
        run_op(1'b1, 32'h80000000, 32'h80000000, 64'h40000000_00000000, "mult_minxmin", 1'b0);
        run_op(1'b1, 32'h80000000, 32'd1, 64'hFFFFFFFF_80000000, "mult_minx1", 1'b0);
        run_op(1'b0, 32'd0, 32'd0, 64'h0, "mulu_0x0", 1'b0);
        run_op(1'b0, 32'd3, 32'd5, 64'h0000000F, "ignore_start", 1'b1);

        // Back-to-back: start held in the DONE cycle.
        bus.start = 1'b1; bus.is_signed = 1'b0; bus.op_a = 32'd3; bus.op_b = 32'd5;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("b2b_first");
        c1 = cyc;
        chk("b2b_first_lo", {32'h0, bus.lo}, 64'd15);
        bus.start = 1'b1; bus.op_a = 32'd2; bus.op_b = 32'd2;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("b2b_second");
        chk("b2b_spacing", 64'(cyc - c1), 64'd34);
        chk("b2b_second_res", {bus.hi, bus.lo}, 64'd4);
        @(negedge clk);

        // Abort by asynchronous reset mid-multiply.
        bus.start = 1'b1; bus.is_signed = 1'b0; bus.op_a = 32'hFFFFFFFF; bus.op_b = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", {63'h0, bus.busy}, 64'h0);
        chk("abort_done", {63'h0, bus.done}, 64'h0);
        chk("abort_hilo", {bus.hi, bus.lo}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        chk("abort_no_done", 64'(ndone), 64'h0);

        // Random request stream, including starts during CALC/FIX and in DONE.
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] r[4];
            r[0] = 32'h0; r[1] = 32'hFFFFFFFF; r[2] = 32'h80000000; r[3] = $urandom;
            bus.start     = ($urandom_range(0, 9) == 0);
            bus.is_signed = $urandom_range(0, 1) == 1;
            bus.op_a      = ($urandom_range(0, 3) == 0) ? r[$urandom_range(0, 3)] : $urandom;
            bus.op_b      = ($urandom_range(0, 3) == 0) ? r[$urandom_range(0, 3)] : $urandom;
            @(negedge clk);
        end
        bus.start = 1'b0;
        repeat (40) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
